rr_mux_sel: RTL and testbench
=============================

# rr_mux_sel

Parametrised round-robin multiplexer: selects one of N valid/ready input channels, registers the chosen word with its channel index, and presents it on a valid/ready output. It is the sequential successor to the combinational 8:1 mux in the combinational library. It sits between several producers and one shared consumer, and gives fair, back-pressure-aware access where a plain select-driven mux would need an external controller.

## Interface
- N, 8, number of input channels (2..64, need not be a power of 2)
- W, 1, data width per channel
- SW, $clog2(N), select/index width (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  channel i has a word
- in_ready  output  N  one-hot or zero; channel i word taken this cycle when in_valid[i] & in_ready[i]
- out_data  output  W  registered selected word
- out_sel  output  SW  registered index of the channel out_data came from
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
- force_en  input  1  static select mode (only with RR_MUX_FORCE_EN)
- force_sel  input  SW  static channel index (only with RR_MUX_FORCE_EN)

## Operation
- Output register is a one-entry buffer with two states. EMPTY: out_valid=0. FULL: out_valid=1.
- can_load = !out_valid | out_ready.
- Priority pointer ptr (SW bits) sets the search start. Grant goes to the first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1. The search wraps at N, not 2^SW.
- in_ready = one-hot(grant) when can_load and any in_valid; otherwise all zero. in_ready is combinational from in_valid, ptr, out_valid and out_ready. There is no combinational path from in_data.
- On accept from channel g:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g==N-1) ? 0 : g+1
- Output transfer with no accept: out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous transfer and accept: the register reloads in the same cycle and out_valid stays 1. Full throughput is one word per cycle.
- No accept: ptr holds.
- While out_valid=1 & out_ready=0, out_data and out_sel are stable.
- force_sel >= N with force_en=1: no grant and in_ready=0.

## Timing
- Reset (rst high at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0
  - in_ready=0 during the reset cycle
  - Any word held in the output register is discarded.
- Latency is 1 cycle: an accept at edge k gives out_valid=1 and data after edge k.
- Starvation bound: a continuously valid channel is granted within N accepts.
- Reset mid-stream: the outstanding output word is lost and ptr returns to 0. There is no partial transfer.

## Configuration
- RR_MUX_FORCE_EN defined:
  - force_en and force_sel ports exist.
  - force_en=1: grant = force_sel when in_valid[force_sel] and can_load, otherwise none. ptr does not change.
  - force_en=0: round-robin as above.
- RR_MUX_FORCE_EN undefined: the ports are absent and the block is pure round-robin.

## Test plan
All cases use N=8, W=4 unless stated.
- Reset: hold rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. First accept after release is channel 0.
- Fairness: in_valid=8'hFF, in_data channel i = i, out_ready=1 constantly -> out_sel sequence 0,1,2,…,7,0,1, one word per cycle after 1-cycle latency.
- Sparse wrap: in_valid=8'b1000_0010, ptr=0 -> grants 1,7,1,7. With N=6, in_valid=6'b10_0001 -> grants 0,5,0 (wraps at 6).
- Back-pressure: out_ready=0 for 3 cycles after the first word (channel 2, data 4'hA) -> out_data=4'hA and out_sel=2 stable, in_ready=0. Release out_ready -> next channel granted in the same cycle, out_valid stays 1.
- Forced select (RR_MUX_FORCE_EN): force_en=1, force_sel=5, in_valid=8'hFF -> only channel 5 granted every cycle, ptr unchanged. force_sel=5 with in_valid[5]=0 -> no grant.
- Reset mid-stream: assert rst while out_valid=1 & out_ready=0 -> next cycle out_valid=0 and the word is dropped. After release, grant restarts at channel 0.

Source files
------------

// File: rtl/rr_mux_sel.sv
// -----------------------------------------------------------------------------
// rr_mux_sel
//
// Round-robin multiplexer. It picks one of N valid/ready input channels,
// registers the chosen word together with its channel index, and presents
// the result on a valid/ready output. The output register is a one-entry
// buffer. It can reload in the same cycle it is drained, which gives one word
// per cycle at full throughput.
//
// Parameters:
//   N   number of input channels (2..64, need not be a power of 2)
//   W   data width per channel
//   SW  index width, derived as $clog2(N)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    N*W packed words; channel i occupies [i*W +: W]
//   in_valid   per-channel word-present flags
//   in_ready   one-hot (or zero) grant; channel i is taken when
//              in_valid[i] & in_ready[i]
//   out_data   registered selected word
//   out_sel    registered index of the channel out_data came from
//   out_valid  output register holds a word
//   out_ready  consumer accepts; a transfer happens on out_valid & out_ready
//   force_en   static select mode            (only with RR_MUX_FORCE_EN)
//   force_sel  static channel index          (only with RR_MUX_FORCE_EN)
//
// Optional feature macro: RR_MUX_FORCE_EN. When it is defined, force_en and
// force_sel exist. When force_en=1, only channel force_sel may be granted,
// and the priority pointer is frozen.
// -----------------------------------------------------------------------------
module rr_mux_sel #(
  parameter  int N  = 8,
  parameter  int W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
`ifdef RR_MUX_FORCE_EN
  input  logic           force_en,
  input  logic [SW-1:0]  force_sel,
`endif
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] ptr, ptr_next;

  logic [W-1:0]  chan_data [N];
  logic          can_load;
  logic          accept;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW:0]   cand;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic          hold_ptr;

  // Unpack the flat input bus so the data path is a plain indexed select.
  // No in_data bit reaches in_ready.
  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan_data[i] = in_data[i*W +: W];
  end

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;

  // Search ptr, ptr+1, ... and wrap at N rather than 2^SW. The sum is one bit
  // wider than SW, so ptr + k cannot overflow before the wrap is applied.
  // NOTE: every variable written in always_comb is given a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (SW+1)'(k);
      if (cand >= (SW+1)'(N)) begin
        cand = cand - (SW+1)'(N);
      end
      if (!rr_found && in_valid[cand[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SW-1:0];
      end
    end
  end

  // Final grant source: the round-robin result, or the forced channel.
  always_comb begin
    grant_found = rr_found;
    grant_idx   = rr_idx;
    hold_ptr    = 1'b0;
`ifdef RR_MUX_FORCE_EN
    if (force_en) begin
      // An out-of-range index never grants. The pointer is frozen in this
      // mode whether or not anything is taken.
      hold_ptr    = 1'b1;
      grant_idx   = force_sel;
      grant_found = ({1'b0, force_sel} < (SW+1)'(N)) && in_valid[force_sel];
    end
`endif
  end

  // in_ready stays low during the reset cycle, so no word is taken and then lost.
  assign accept = grant_found && can_load && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next state for the output buffer and the pointer. An accept wins over a
  // drain, so a simultaneous transfer and accept keeps the buffer FULL.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (accept) begin
      state_next = FULL;
      if (!hold_ptr) begin
        ptr_next = (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      state_next = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      // The payload only moves on an accept, so it holds under back-pressure
      // and after a drain.
      if (accept) begin
        out_data <= chan_data[grant_idx];
        out_sel  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_sel.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_sel
//
// Self-checking bench for rr_mux_sel.
// The main instance uses N=8, W=4. A second instance uses N=6 to cover the
// wrap at a non-power-of-two channel count.
//
// Each cycle, the stimulus task drives the inputs and updates a
// channel-level reference model (an integer priority pointer, modulo-N
// search, a full/empty flag). It pushes every word the model expects to be
// accepted into a queue. A monitor on the falling edge compares in_ready and
// out_valid against the model, and compares the presented word against the
// head of the queue. It pops the head when the consumer takes the word.
// -----------------------------------------------------------------------------
module tb_rr_mux_sel;

  localparam int N = 8;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           force_en = 1'b0;
  logic [2:0]     force_sel = '0;
  logic           nxt_force_en = 1'b0;
  logic [2:0]     nxt_force_sel = '0;

  logic [23:0]    in_data6 = '0;
  logic [5:0]     in_valid6 = '0;
  logic [5:0]     in_ready6;
  logic [3:0]     out_data6;
  logic [2:0]     out_sel6;
  logic           out_valid6;
  logic           out_ready6 = 1'b1;
`ifdef RR_MUX_FORCE_EN
  logic           force_en6 = 1'b0;
  logic [2:0]     force_sel6 = '0;
`endif

  always #5 clk = ~clk;

  rr_mux_sel #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_MUX_FORCE_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux_sel #(.N(6), .W(4)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data6),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
`ifdef RR_MUX_FORCE_EN
    .force_en  (force_en6),
    .force_sel (force_sel6),
`endif
    .out_data  (out_data6),
    .out_sel   (out_sel6),
    .out_valid (out_valid6),
    .out_ready (out_ready6)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   sel;
  } item_t;

  item_t      sb[$];
  int         n_checks = 0;
  int         n_fail = 0;

  // Reference model state: state after the most recent edge.
  int         m_ptr = 0;
  bit         m_full = 1'b0;
  logic [N-1:0] exp_ready = '0;
  logic       exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The first channel with a word, searching from start in modulo-N order.
  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle of stimulus plus the model update for that cycle.
  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic r, input logic rs);
    int g;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    force_en  = nxt_force_en;
    force_sel = nxt_force_sel;
    exp_valid = m_full;
    exp_ready = '0;
    if (rs) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else begin
      if (force_en)
        g = (int'(force_sel) < N && v[force_sel]) ? int'(force_sel) : -1;
      else
        g = rr_pick(v, m_ptr);
      if ((!m_full || r) && g >= 0) begin
        exp_ready[g] = 1'b1;
        sb.push_back(item_t'{data: d[g*W +: W], sel: 3'(g)});
        m_full = 1'b1;
        if (!force_en) m_ptr = (g + 1) % N;
      end else if (r) begin
        m_full = 1'b0;
      end
    end
  endtask

  // Monitor: compares the DUT against the model halfway through each cycle.
  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_word: out_valid=1 sel=%0d but no word expected (t=%0t)", out_sel, $time);
      end else begin
        check("out_data", 32'(out_data), 32'(sb[0].data));
        check("out_sel", 32'(out_sel), 32'(sb[0].sel));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [N*W-1:0] idx_data;
    logic [N*W-1:0] bp_data;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    int             exp6 [4];

    for (int i = 0; i < N; i++) idx_data[i*W +: W] = W'(i);
    for (int i = 0; i < 6; i++) in_data6[i*4 +: 4] = 4'(i);

    // Reset held two cycles with every channel valid.
    drive('1, idx_data, 1'b1, 1'b1);
    drive('1, idx_data, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);

    // Fairness: all valid, consumer always ready -> 0,1,...,7,0,1,...
    repeat (18) drive('1, idx_data, 1'b1, 1'b0);

    // Sparse wrap from ptr=0: 1,7,1,7,...
    drive('0, idx_data, 1'b1, 1'b1);
    repeat (6) drive(8'b1000_0010, idx_data, 1'b1, 1'b0);

    // Back-pressure: first word is channel 2 carrying 4'hA, then a 3-cycle stall.
    drive('0, idx_data, 1'b1, 1'b1);
    bp_data = idx_data;
    bp_data[2*W +: W] = 4'hA;
    drive(8'b0000_0100, bp_data, 1'b1, 1'b0);
    repeat (3) drive('1, bp_data, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_hold_data", 32'(out_data), 32'hA);
    check("bp_hold_sel", 32'(out_sel), 32'd2);
    repeat (4) drive('1, bp_data, 1'b1, 1'b0);

    // N=6 instance: valid on channels 0 and 5 -> 0,5,0,5 (wrap at 6).
    exp6[0] = 0; exp6[1] = 5; exp6[2] = 0; exp6[3] = 5;
    drive('0, idx_data, 1'b1, 1'b1);
    drive('0, idx_data, 1'b1, 1'b0);
    in_valid6 = 6'b10_0001;
    for (int i = 0; i < 4; i++) begin
      drive('0, idx_data, 1'b1, 1'b0);
      @(negedge clk);
      check("n6_valid", 32'(out_valid6), 32'd1);
      check("n6_sel", 32'(out_sel6), 32'(exp6[i]));
    end
    in_valid6 = '0;

`ifdef RR_MUX_FORCE_EN
    // Forced select: only channel 5 while forced; the pointer stays at 0.
    drive('0, idx_data, 1'b1, 1'b1);
    nxt_force_en  = 1'b1;
    nxt_force_sel = 3'd5;
    repeat (4) drive('1, idx_data, 1'b1, 1'b0);
    repeat (2) drive(8'hDF, idx_data, 1'b1, 1'b0);
    nxt_force_en = 1'b0;
    repeat (3) drive('1, idx_data, 1'b1, 1'b0);
`endif

    // Reset mid-stream while the output word is stalled.
    drive('1, idx_data, 1'b1, 1'b0);
    drive('1, idx_data, 1'b1, 1'b0);
    drive('1, idx_data, 1'b0, 1'b0);
    drive('1, idx_data, 1'b0, 1'b1);
    repeat (3) drive('1, idx_data, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      rv = N'($urandom);
      rd = {$urandom};
`ifdef RR_MUX_FORCE_EN
      nxt_force_en  = ($urandom_range(0, 7) == 0);
      nxt_force_sel = 3'($urandom);
`endif
      drive(rv, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
    end
    nxt_force_en = 1'b0;

    // Drain.
    repeat (3) drive('0, idx_data, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
